lever_ctrl: RTL and testbench

Per-lever sequencing controller for the Fireboy/Watergirl level. It samples both player positions once per frame and detects a player walking into the lever hitbox. On that event it runs a four-step swing animation and latches the lever state. It also ramps the linked moving-platform offset one pixel per frame. Outputs drive the lever sprite renderer's `lever_flipped` input and frame select, and the platform sprite/collision logic.

---
 rtl/lever_ctrl.sv | 141 ++++++++++++++
 tb/tb_lever_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lever_ctrl.sv
// Lever sequencing controller: detects a player walking into the lever
// hitbox, plays a four-step swing animation, latches the lever state and
// ramps the linked moving platform one pixel per frame.
module lever_ctrl #(
  parameter int LEVER_X         = 146,
  parameter int LEVER_Y         = 329,
  parameter int LEVER_HALF      = 10,
  parameter int PLAYER_HALF     = 12,
  parameter int PLATFORM_TRAVEL = 64
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] fb_x,
  input  logic [9:0] fb_y,
  input  logic [9:0] wg_x,
  input  logic [9:0] wg_y,
  output logic       lever_flipped,
  output logic [1:0] anim_stage,
  output logic       busy,
  output logic [6:0] platform_offset,
  output logic       platform_moving
);

  // Hitbox geometry in the 11-bit signed domain used for the distance math.
  localparam logic signed [10:0] CENTRE_X = 11'(LEVER_X);
  localparam logic signed [10:0] CENTRE_Y = 11'(LEVER_Y);
  localparam logic [10:0]        REACH    = 11'(LEVER_HALF + PLAYER_HALF);
  localparam logic [6:0]         TRAVEL   = 7'(PLATFORM_TRAVEL);

  typedef enum logic [1:0] {
    IDLE_OFF  = 2'd0,
    SWING_ON  = 2'd1,
    IDLE_ON   = 2'd2,
    SWING_OFF = 2'd3
  } state_t;

  state_t state;
  logic   prev_fb;
  logic   prev_wg;
  logic   ov_fb;
  logic   ov_wg;
  logic   trigger;
  logic   on_target;

  // True when a 10-bit coordinate lies within REACH of the given centre
  // (distance exactly equal to REACH still counts as a hit).
  function automatic logic axis_hit(input logic [9:0] pos, input logic signed [10:0] centre);
    logic signed [10:0] diff;
    logic [10:0]        mag;
    diff = $signed({1'b0, pos}) - centre;
    mag  = diff[10] ? unsigned'(-diff) : unsigned'(diff);
    return (mag <= REACH);
  endfunction

  // Combinational overlap of each player with the lever and rising-edge trigger.
  always_comb begin
    ov_fb   = axis_hit(fb_x, CENTRE_X) & axis_hit(fb_y, CENTRE_Y);
    ov_wg   = axis_hit(wg_x, CENTRE_X) & axis_hit(wg_y, CENTRE_Y);
    trigger = (ov_fb & ~prev_fb) | (ov_wg & ~prev_wg);
  end

  // Lever sequencer: overlap history, swing animation and latched lever state.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE_OFF;
      prev_fb       <= 1'b0;
      prev_wg       <= 1'b0;
      lever_flipped <= 1'b0;
      anim_stage    <= 2'd0;
      busy          <= 1'b0;
    end else if (frame_tick) begin
      // History tracks overlap on every tick, even while a swing discards
      // triggers, so a player parked on the lever never retriggers.
      prev_fb <= ov_fb;
      prev_wg <= ov_wg;
      case (state)
        IDLE_OFF: begin
          if (trigger) begin
            state      <= SWING_ON;
            anim_stage <= 2'd1;
            busy       <= 1'b1;
          end
        end
        SWING_ON: begin
          anim_stage <= anim_stage + 2'd1;
          if (anim_stage == 2'd2) begin
            state         <= IDLE_ON;
            lever_flipped <= 1'b1;
            busy          <= 1'b0;
          end
        end
        IDLE_ON: begin
          if (trigger) begin
            state      <= SWING_OFF;
            anim_stage <= 2'd2;
            busy       <= 1'b1;
          end
        end
        SWING_OFF: begin
          anim_stage <= anim_stage - 2'd1;
          if (anim_stage == 2'd1) begin
            state         <= IDLE_OFF;
            lever_flipped <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE_OFF;
          anim_stage <= 2'd0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Platform heads for full travel while the lever is swinging on or is on.
  always_comb begin
    on_target = (state == SWING_ON) || (state == IDLE_ON);
  end

  // Platform ramp: one pixel per tick toward the target, saturating there;
  // a new target mid-travel simply reverses from the current offset.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      platform_offset <= 7'd0;
      platform_moving <= 1'b0;
    end else if (frame_tick) begin
      if (on_target && (platform_offset < TRAVEL)) begin
        platform_offset <= platform_offset + 7'd1;
        platform_moving <= 1'b1;
      end else if (!on_target && (platform_offset != 7'd0)) begin
        platform_offset <= platform_offset - 7'd1;
        platform_moving <= 1'b1;
      end else begin
        platform_moving <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lever_ctrl.sv
// Directed testbench for lever_ctrl with default parameters.
module tb_lever_ctrl;

  logic       vga_clk;
  logic       reset;
  logic       frame_tick;
  logic [9:0] fb_x, fb_y, wg_x, wg_y;
  logic       lever_flipped;
  logic [1:0] anim_stage;
  logic       busy;
  logic [6:0] platform_offset;
  logic       platform_moving;

  int checks;
  int errors;
  int tick_no;

  lever_ctrl dut (
    .vga_clk         (vga_clk),
    .reset           (reset),
    .frame_tick      (frame_tick),
    .fb_x            (fb_x),
    .fb_y            (fb_y),
    .wg_x            (wg_x),
    .wg_y            (wg_y),
    .lever_flipped   (lever_flipped),
    .anim_stage      (anim_stage),
    .busy            (busy),
    .platform_offset (platform_offset),
    .platform_moving (platform_moving)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // One frame tick: pulse for one cycle, then sample on the following negedge.
  task automatic tick();
    @(negedge vga_clk) frame_tick = 1'b1;
    @(negedge vga_clk) frame_tick = 1'b0;
    tick_no++;
    $display("tick %0d fb=(%0d,%0d) wg=(%0d,%0d) stage=%0d busy=%0b flip=%0b off=%0d mov=%0b",
             tick_no, fb_x, fb_y, wg_x, wg_y, anim_stage, busy, lever_flipped,
             platform_offset, platform_moving);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge vga_clk) reset = 1'b1;
    @(negedge vga_clk) reset = 1'b0;
    tick_no = 0;
  endtask

  task automatic place(input int fx, input int fy, input int wx, input int wy);
    fb_x = 10'(fx); fb_y = 10'(fy); wg_x = 10'(wx); wg_y = 10'(wy);
  endtask

  task automatic test_reset();
    place(0, 0, 0, 0);
    do_reset();
    checks++;
    if ({lever_flipped, anim_stage, busy, platform_offset, platform_moving} !== 12'd0) begin
      errors++;
      $display("FAIL reset_state got flip=%0b stage=%0d busy=%0b off=%0d mov=%0b want all 0",
               lever_flipped, anim_stage, busy, platform_offset, platform_moving);
    end
  endtask

  task automatic test_swing_on();
    place(146, 329, 0, 0);
    do_reset();
    tick();
    checks++;
    if (anim_stage !== 2'd1 || busy !== 1'b1 || lever_flipped !== 1'b0 || platform_offset !== 7'd0) begin
      errors++;
      $display("FAIL swing_on_t1 got stage=%0d busy=%0b flip=%0b off=%0d want 1 1 0 0",
               anim_stage, busy, lever_flipped, platform_offset);
    end
    tick();
    checks++;
    if (anim_stage !== 2'd2 || busy !== 1'b1 || lever_flipped !== 1'b0 || platform_offset !== 7'd1) begin
      errors++;
      $display("FAIL swing_on_t2 got stage=%0d busy=%0b flip=%0b off=%0d want 2 1 0 1",
               anim_stage, busy, lever_flipped, platform_offset);
    end
    tick();
    checks++;
    if (anim_stage !== 2'd3 || busy !== 1'b0 || lever_flipped !== 1'b1 || platform_offset !== 7'd2) begin
      errors++;
      $display("FAIL swing_on_t3 got stage=%0d busy=%0b flip=%0b off=%0d want 3 0 1 2",
               anim_stage, busy, lever_flipped, platform_offset);
    end
    ticks(3);
    checks++;
    if (anim_stage !== 2'd3 || busy !== 1'b0 || lever_flipped !== 1'b1 || platform_offset !== 7'd5) begin
      errors++;
      $display("FAIL no_retrigger got stage=%0d busy=%0b flip=%0b off=%0d want 3 0 1 5",
               anim_stage, busy, lever_flipped, platform_offset);
    end
  endtask

  task automatic test_swing_off();
    place(146, 329, 0, 0);
    do_reset();
    ticks(3);                 // IDLE_ON, offset 2
    place(0, 0, 0, 0);
    tick();                   // offset 3
    place(146, 329, 0, 0);
    tick();                   // trigger from IDLE_ON: stage 2, offset 4
    checks++;
    if (anim_stage !== 2'd2 || busy !== 1'b1 || lever_flipped !== 1'b1 || platform_offset !== 7'd4) begin
      errors++;
      $display("FAIL swing_off_t1 got stage=%0d busy=%0b flip=%0b off=%0d want 2 1 1 4",
               anim_stage, busy, lever_flipped, platform_offset);
    end
    tick();
    checks++;
    if (anim_stage !== 2'd1 || busy !== 1'b1 || platform_offset !== 7'd3 || platform_moving !== 1'b1) begin
      errors++;
      $display("FAIL swing_off_t2 got stage=%0d busy=%0b off=%0d mov=%0b want 1 1 3 1",
               anim_stage, busy, platform_offset, platform_moving);
    end
    tick();
    checks++;
    if (anim_stage !== 2'd0 || busy !== 1'b0 || lever_flipped !== 1'b0 || platform_offset !== 7'd2) begin
      errors++;
      $display("FAIL swing_off_t3 got stage=%0d busy=%0b flip=%0b off=%0d want 0 0 0 2",
               anim_stage, busy, lever_flipped, platform_offset);
    end
    ticks(2);
    checks++;
    if (platform_offset !== 7'd0 || platform_moving !== 1'b1) begin
      errors++;
      $display("FAIL ramp_down_end got off=%0d mov=%0b want 0 1", platform_offset, platform_moving);
    end
    tick();
    checks++;
    if (platform_offset !== 7'd0 || platform_moving !== 1'b0 || anim_stage !== 2'd0) begin
      errors++;
      $display("FAIL ramp_down_idle got off=%0d mov=%0b stage=%0d want 0 0 0",
               platform_offset, platform_moving, anim_stage);
    end
  endtask

  // Hitbox edges: reach is 22 on each axis, inclusive.
  task automatic test_boundary();
    int vx[6] = '{168, 169, 124, 123, 146, 146};
    int vy[6] = '{329, 329, 329, 329, 351, 352};
    logic [1:0] want[6] = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    for (int i = 0; i < 6; i++) begin
      place(vx[i], vy[i], 0, 0);
      do_reset();
      tick();
      checks++;
      if (anim_stage !== want[i] || busy !== want[i][0]) begin
        errors++;
        $display("FAIL boundary_%0d_%0d got stage=%0d busy=%0b want stage=%0d",
                 vx[i], vy[i], anim_stage, busy, want[i]);
      end
    end
  endtask

  task automatic test_both_players();
    place(146, 329, 146, 329);
    do_reset();
    tick();
    checks++;
    if (anim_stage !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_t1 got stage=%0d busy=%0b want 1 1", anim_stage, busy);
    end
    ticks(3);
    checks++;
    if (anim_stage !== 2'd3 || busy !== 1'b0 || lever_flipped !== 1'b1) begin
      errors++;
      $display("FAIL both_settle got stage=%0d busy=%0b flip=%0b want 3 0 1",
               anim_stage, busy, lever_flipped);
    end
  endtask

  task automatic test_ignore_during_swing();
    place(146, 329, 0, 0);
    do_reset();
    tick();
    place(146, 329, 150, 330);
    tick();
    checks++;
    if (anim_stage !== 2'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_mid got stage=%0d busy=%0b want 2 1", anim_stage, busy);
    end
    ticks(3);
    checks++;
    if (anim_stage !== 2'd3 || busy !== 1'b0 || lever_flipped !== 1'b1) begin
      errors++;
      $display("FAIL ignore_end got stage=%0d busy=%0b flip=%0b want 3 0 1",
               anim_stage, busy, lever_flipped);
    end
  endtask

  // Position changes without a tick must not be seen.
  task automatic test_glitch();
    place(0, 0, 0, 0);
    do_reset();
    place(146, 329, 0, 0);
    repeat (3) @(negedge vga_clk);
    place(0, 0, 0, 0);
    tick();
    checks++;
    if (anim_stage !== 2'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch got stage=%0d busy=%0b want 0 0", anim_stage, busy);
    end
  endtask

  task automatic test_platform();
    place(146, 329, 0, 0);
    do_reset();
    ticks(64);
    checks++;
    if (platform_offset !== 7'd63 || platform_moving !== 1'b1) begin
      errors++;
      $display("FAIL plat_63 got off=%0d mov=%0b want 63 1", platform_offset, platform_moving);
    end
    tick();
    checks++;
    if (platform_offset !== 7'd64 || platform_moving !== 1'b1) begin
      errors++;
      $display("FAIL plat_64 got off=%0d mov=%0b want 64 1", platform_offset, platform_moving);
    end
    tick();
    checks++;
    if (platform_offset !== 7'd64 || platform_moving !== 1'b0) begin
      errors++;
      $display("FAIL plat_sat got off=%0d mov=%0b want 64 0", platform_offset, platform_moving);
    end
  endtask

  task automatic test_async_reset();
    place(146, 329, 0, 0);
    do_reset();
    ticks(31);
    checks++;
    if (platform_offset !== 7'd30) begin
      errors++;
      $display("FAIL pre_reset_off got off=%0d want 30", platform_offset);
    end
    @(negedge vga_clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({lever_flipped, anim_stage, busy, platform_offset, platform_moving} !== 12'd0) begin
      errors++;
      $display("FAIL async_reset got flip=%0b stage=%0d busy=%0b off=%0d mov=%0b want all 0",
               lever_flipped, anim_stage, busy, platform_offset, platform_moving);
    end
    @(negedge vga_clk) reset = 1'b0;
    tick_no = 0;
    tick();
    checks++;
    if (anim_stage !== 2'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL retrigger_after_reset got stage=%0d busy=%0b want 1 1", anim_stage, busy);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    tick_no    = 0;
    reset      = 1'b1;
    frame_tick = 1'b0;
    place(0, 0, 0, 0);
    test_reset();
    test_swing_on();
    test_swing_off();
    test_boundary();
    test_both_players();
    test_ignore_during_swing();
    test_glitch();
    test_platform();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
